// File: rtl/led_pio_ctrl.sv
// Avalon-MM LED/output-port controller: DATA/MODE/PERIOD/DUTY registers,
// atomic set/clear/toggle writes, per-bit blink and global PWM brightness.
module led_pio_ctrl #(
    parameter int unsigned                WIDTH        = 10,
    parameter logic [WIDTH-1:0]           RESET_VALUE  = WIDTH'(5),
    parameter int unsigned                PERIOD_BITS  = 16,
    parameter logic [PERIOD_BITS-1:0]     PERIOD_RESET = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [WIDTH-1:0]  out_port
);

    localparam logic [2:0] AddrData   = 3'd0;
    localparam logic [2:0] AddrMode   = 3'd1;
    localparam logic [2:0] AddrPeriod = 3'd2;
    localparam logic [2:0] AddrDuty   = 3'd3;
    localparam logic [2:0] AddrSet    = 3'd4;
    localparam logic [2:0] AddrClear  = 3'd5;
    localparam logic [2:0] AddrToggle = 3'd6;
    localparam logic [2:0] AddrStatus = 3'd7;

    logic [WIDTH-1:0]       data_q, data_d;
    logic [WIDTH-1:0]       mode_q, mode_d;
    logic [PERIOD_BITS-1:0] period_q, period_d;
    logic [7:0]             duty_q, duty_d;
    logic [PERIOD_BITS-1:0] cnt_q, cnt_d;
    logic                   phase_q, phase_d;
    logic [7:0]             pwm_cnt_q, pwm_cnt_d;
    logic [WIDTH-1:0]       out_q, out_d;

    logic                   wr_en;
    logic [WIDTH-1:0]       wd;
    logic                   pwm_on;
    logic                   unused_writedata;

    assign wr_en            = chipselect & ~write_n;
    assign wd               = writedata[WIDTH-1:0];
    assign unused_writedata = ^writedata;

    // Register-file next state, including the read-modify-write aliases.
    always_comb begin
        data_d   = data_q;
        mode_d   = mode_q;
        period_d = period_q;
        duty_d   = duty_q;
        if (wr_en) begin
            case (address)
                AddrData:   data_d   = wd;
                AddrMode:   mode_d   = wd;
                AddrPeriod: period_d = writedata[PERIOD_BITS-1:0];
                AddrDuty:   duty_d   = writedata[7:0];
                AddrSet:    data_d   = data_q | wd;
                AddrClear:  data_d   = data_q & ~wd;
                AddrToggle: data_d   = data_q ^ wd;
                default:    ;  // STATUS is read-only
            endcase
        end
    end

    // Blink prescaler and PWM counter; a PERIOD write restarts the prescaler
    // without toggling, even if the old terminal count was reached.
    always_comb begin
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        pwm_cnt_d = pwm_cnt_q + 8'd1;
        if (wr_en && (address == AddrPeriod)) begin
            cnt_d = '0;
        end else if (cnt_q == period_q) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + PERIOD_BITS'(1);
        end
    end

    // Output drive: blink-gated data, then globally gated by PWM.
    always_comb begin
        pwm_on = (duty_q == 8'hFF) || (pwm_cnt_q < duty_q);
        out_d  = data_q & (~mode_q | {WIDTH{phase_q}}) & {WIDTH{pwm_on}};
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q    <= RESET_VALUE;
            mode_q    <= '0;
            period_q  <= PERIOD_RESET;
            duty_q    <= 8'hFF;
            cnt_q     <= '0;
            phase_q   <= 1'b1;
            pwm_cnt_q <= 8'd0;
            out_q     <= RESET_VALUE;
        end else begin
            data_q    <= data_d;
            mode_q    <= mode_d;
            period_q  <= period_d;
            duty_q    <= duty_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            pwm_cnt_q <= pwm_cnt_d;
            out_q     <= out_d;
        end
    end

    // Zero-wait-state read mux; write-only addresses and unused bits read 0.
    always_comb begin
        readdata = '0;
        case (address)
            AddrData:   readdata[WIDTH-1:0]       = data_q;
            AddrMode:   readdata[WIDTH-1:0]       = mode_q;
            AddrPeriod: readdata[PERIOD_BITS-1:0] = period_q;
            AddrDuty:   readdata[7:0]             = duty_q;
            AddrStatus: begin
                readdata[0]    = phase_q;
                readdata[15:8] = pwm_cnt_q;
            end
            default:    readdata = '0;
        endcase
    end

    assign out_port = out_q;

endmodule
